// File: rtl/cms_pkg.sv
// cms_pkg: command codes, FSM state encoding and timing defaults shared by the responder.
package cms_pkg;
  localparam int T_SETUP_DEF = 4;
  localparam int T_VALID_DEF = 4;
  localparam int T_HOLD_DEF = 4;
  localparam int T_GAP_DEF = 2;
  localparam logic [7:0] DEVICE_ID_DEF = 8'hA5;
  typedef enum logic [2:0] {
    CMD_READ_FIFO = 3'd1,
    CMD_STATUS = 3'd2,
    CMD_ID = 3'd3
  } cmd_e;
  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_VALID, S_HOLD, S_GAP, S_MUTE} state_e;
  function automatic logic cmd_supported(input logic [2:0] c);
    return c == CMD_READ_FIFO || c == CMD_STATUS || c == CMD_ID;
  endfunction
endpackage

// File: rtl/cms_byte_fifo.sv
// cms_byte_fifo: synchronous 16x8 FIFO; writes while full and reads while empty are ignored.
module cms_byte_fifo (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       rd_en,
  output logic [7:0] head,
  output logic       full,
  output logic       empty,
  output logic [4:0] count
);
  logic [7:0] mem [16];
  logic [3:0] wptr, rptr;
  logic push, pop;
  assign full = count == 5'd16;
  assign empty = count == 5'd0;
  assign push = wr_en && !full;
  assign pop = rd_en && !empty;
  assign head = mem[rptr];
  always_ff @(posedge clk) if (push) mem[wptr] <= wr_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else begin
      wptr <= wptr + 4'(push);
      rptr <= rptr + 4'(pop);
      count <= count + 5'(push) - 5'(pop);
    end
  end
endmodule

// File: rtl/cms_data_responder.sv
// cms_data_responder: chip-select driven byte responder serving FIFO data, status or a device ID.
module cms_data_responder
  import cms_pkg::*;
#(
  parameter int T_SETUP = T_SETUP_DEF,
  parameter int T_VALID = T_VALID_DEF,
  parameter int T_HOLD = T_HOLD_DEF,
  parameter int T_GAP = T_GAP_DEF,
  parameter logic [7:0] DEVICE_ID = DEVICE_ID_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs_i,
  input  logic [2:0]  cmd_code_i,
  output logic        data_valid_o,
  output logic [7:0]  data_o,
  input  logic        wr_en_i,
  input  logic [7:0]  wr_data_i,
  input  logic        clr_i,
  output logic [4:0]  fifo_count_o,
  output logic        overflow_o,
  output logic        underflow_o,
  output logic [15:0] tx_count_o
);
  localparam logic [7:0] SETUP_LOAD = 8'(T_SETUP - 2);
  localparam logic [7:0] SETUP_END = 8'(T_SETUP - 1);
  localparam logic [7:0] VALID_END = 8'(T_VALID - 1);
  localparam logic [7:0] HOLD_END = 8'(T_HOLD - 1);
  localparam logic [7:0] GAP_END = 8'(T_GAP - 1);
  state_e state, state_n;
  logic [7:0] cnt, cnt_n, data_n, head, sel_byte;
  logic [2:0] cmd, cmd_n;
  logic valid_n, src, src_n, sel_src, load, pop, done, full, empty, udf_set;
  cms_byte_fifo u_fifo (
    .clk(clk), .rst(rst), .wr_en(wr_en_i), .wr_data(wr_data_i), .rd_en(pop),
    .head(head), .full(full), .empty(empty), .count(fifo_count_o)
  );
  // src remembers whether the byte on data_o came from the FIFO, so only real FIFO bytes get popped
  assign sel_src = cmd == CMD_READ_FIFO && !empty;
  assign sel_byte = cmd == CMD_READ_FIFO ? (empty ? 8'hFF : head) :
                    cmd == CMD_STATUS ? {underflow_o, overflow_o, 1'b0, fifo_count_o} : DEVICE_ID;
  assign udf_set = load && cmd == CMD_READ_FIFO && empty;
  always_comb begin
    state_n = state;
    cnt_n = cnt + 8'd1;
    cmd_n = cmd;
    valid_n = 1'b0;
    load = 1'b0;
    pop = 1'b0;
    done = 1'b0;
    if (state == S_IDLE) begin
      cnt_n = '0;
      if (!cs_i) begin
        cmd_n = cmd_code_i;
        state_n = cmd_supported(cmd_code_i) ? S_SETUP : S_MUTE;
      end
    end else if (cs_i) begin
      state_n = S_IDLE;
      cnt_n = '0;
    end else begin
      case (state)
        S_SETUP: begin
          load = cnt == SETUP_LOAD;
          valid_n = cnt == SETUP_END;
          state_n = cnt == SETUP_END ? S_VALID : S_SETUP;
        end
        S_VALID: begin
          valid_n = cnt != VALID_END;
          state_n = cnt == VALID_END ? S_HOLD : S_VALID;
        end
        S_HOLD: begin
          done = cnt == HOLD_END;
          pop = done && src;
          state_n = done ? S_GAP : S_HOLD;
        end
        S_GAP: begin
          load = cnt == GAP_END;
          valid_n = load;
          state_n = load ? S_VALID : S_GAP;
        end
        default: cnt_n = '0;
      endcase
      cnt_n = state_n != state ? 8'd0 : cnt_n;
    end
    data_n = load ? sel_byte : data_o;
    src_n = load ? sel_src : src;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt <= '0;
      cmd <= '0;
      src <= 1'b0;
      data_valid_o <= 1'b0;
      data_o <= '0;
      overflow_o <= 1'b0;
      underflow_o <= 1'b0;
      tx_count_o <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      cmd <= cmd_n;
      src <= src_n;
      data_valid_o <= valid_n;
      data_o <= data_n;
      overflow_o <= (wr_en_i && full) || (overflow_o && !clr_i);
      underflow_o <= udf_set || (underflow_o && !clr_i);
      tx_count_o <= (clr_i ? 16'd0 : tx_count_o) + 16'(done);
    end
  end
endmodule

// File: tb/tb_cms_data_responder.sv
// tb_cms_data_responder: directed self-checking bench for cms_data_responder.
module tb_cms_data_responder;
  logic clk = 1'b0, rst = 1'b1, cs_i = 1'b1, wr_en_i = 1'b0, clr_i = 1'b0;
  logic [2:0] cmd_code_i = 3'd0;
  logic [7:0] wr_data_i = 8'h00, data_o;
  logic data_valid_o, overflow_o, underflow_o;
  logic [4:0] fifo_count_o;
  logic [15:0] tx_count_o;
  int pass_cnt = 0, total = 0;
  cms_data_responder dut (
    .clk(clk), .rst(rst), .cs_i(cs_i), .cmd_code_i(cmd_code_i), .data_valid_o(data_valid_o),
    .data_o(data_o), .wr_en_i(wr_en_i), .wr_data_i(wr_data_i), .clr_i(clr_i),
    .fifo_count_o(fifo_count_o), .overflow_o(overflow_o), .underflow_o(underflow_o),
    .tx_count_o(tx_count_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got == exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [7:0] d);
    wr_en_i = 1'b1;
    wr_data_i = d;
    tick();
    wr_en_i = 1'b0;
  endtask
  task automatic start(input logic [2:0] c);
    cmd_code_i = c;
    cs_i = 1'b0;
  endtask
  task automatic stop();
    cs_i = 1'b1;
    tick();
    tick();
  endtask
  // lat counts edges from the call until data_valid_o is seen high; ends on the first hold cycle
  task automatic get_byte(input string tag, input int exp_lat, input logic [7:0] exp);
    int n, w;
    n = 0;
    do begin tick(); n++; end while (!data_valid_o && n < 64);
    chk({tag, "_lat"}, n, exp_lat);
    chk({tag, "_data"}, data_o, exp);
    w = 0;
    while (data_valid_o && w < 64) begin tick(); w++; end
    chk({tag, "_width"}, w, 4);
    chk({tag, "_hold"}, data_o, exp);
  endtask
  initial begin
    int seen;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_valid", data_valid_o, 0);
    chk("rst_data", data_o, 0);
    chk("rst_count", fifo_count_o, 0);
    chk("rst_ovf", overflow_o, 0);
    chk("rst_udf", underflow_o, 0);
    chk("rst_tx", tx_count_o, 0);
    wr(8'h11);
    wr(8'h22);
    chk("rd_count0", fifo_count_o, 2);
    start(3'd1);
    get_byte("rd_b1", 5, 8'h11);
    chk("rd_count1", fifo_count_o, 2);
    get_byte("rd_b2", 6, 8'h22);
    repeat (4) tick();
    chk("rd_count2", fifo_count_o, 0);
    chk("rd_tx", tx_count_o, 2);
    chk("rd_udf", underflow_o, 0);
    stop();
    start(3'd3);
    get_byte("id_b1", 5, 8'hA5);
    get_byte("id_b2", 6, 8'hA5);
    get_byte("id_b3", 6, 8'hA5);
    repeat (4) tick();
    stop();
    chk("id_tx", tx_count_o, 5);
    chk("id_count", fifo_count_o, 0);
    start(3'd1);
    get_byte("udf_b", 5, 8'hFF);
    chk("udf_flag", underflow_o, 1);
    stop();
    chk("udf_count", fifo_count_o, 0);
    start(3'd2);
    get_byte("stat_b", 5, 8'h80);
    stop();
    chk("abort_tx", tx_count_o, 5);
    clr_i = 1'b1;
    tick();
    clr_i = 1'b0;
    chk("clr_udf", underflow_o, 0);
    chk("clr_tx", tx_count_o, 0);
    for (int i = 0; i < 17; i++) wr(8'h40 + 8'(i));
    chk("full_count", fifo_count_o, 16);
    chk("full_ovf", overflow_o, 1);
    clr_i = 1'b1;
    tick();
    clr_i = 1'b0;
    chk("clr_ovf", overflow_o, 0);
    chk("clr_count", fifo_count_o, 16);
    clr_i = 1'b1;
    wr(8'hEE);
    clr_i = 1'b0;
    chk("clr_vs_set", overflow_o, 1);
    chk("clr_vs_set_cnt", fifo_count_o, 16);
    clr_i = 1'b1;
    tick();
    clr_i = 1'b0;
    start(3'd1);
    seen = 0;
    do begin tick(); seen++; end while (!data_valid_o && seen < 64);
    chk("ab_data", data_o, 8'h40);
    tick();
    cs_i = 1'b1;
    tick();
    chk("ab_valid", data_valid_o, 0);
    chk("ab_count", fifo_count_o, 16);
    tick();
    chk("ab_tx", tx_count_o, 0);
    start(3'd1);
    get_byte("re_b1", 5, 8'h40);
    repeat (3) tick();
    wr(8'h99);
    chk("popfull_count", fifo_count_o, 15);
    chk("popfull_ovf", overflow_o, 1);
    get_byte("re_b2", 2, 8'h41);
    repeat (3) tick();
    wr(8'h77);
    chk("popwr_count", fifo_count_o, 15);
    chk("popwr_tx", tx_count_o, 2);
    stop();
    start(3'd3);
    repeat (6) tick();
    chk("mid_valid_pre", data_valid_o, 1);
    rst = 1'b1;
    cs_i = 1'b1;
    tick();
    chk("mid_valid", data_valid_o, 0);
    chk("mid_data", data_o, 0);
    chk("mid_count", fifo_count_o, 0);
    chk("mid_ovf", overflow_o, 0);
    chk("mid_tx", tx_count_o, 0);
    rst = 1'b0;
    tick();
    start(3'd5);
    seen = 0;
    repeat (20) begin tick(); seen = seen | int'(data_valid_o); end
    chk("mute_valid", seen, 0);
    stop();
    start(3'd3);
    get_byte("post_mute", 5, 8'hA5);
    stop();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
